// File: rtl/dsd_pipe_pkg.sv
// Shared pipeline definitions: EX/MEM control bit positions, MEM-stage FSM states
// and the data word reported when a data-cache access is abandoned.
package dsd_pipe_pkg;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic logic is_memop(input logic [3:0] ctrl);
    return ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE];
  endfunction

  // MemRead together with MemWrite counts as a store, so a load needs MemWrite clear.
  function automatic logic is_load(input logic [3:0] ctrl);
    return ctrl[CTRL_MEMREAD] & ~ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts wait cycles of an outstanding data-cache access and flags the cycle on
// which the configured limit is reached. TIMEOUT of 0 never expires.
module dmem_wait_timer #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: issues one word load/store at a time to the
// data cache, stalls the pipeline while it is outstanding and feeds MEM/WB.
module mem_stage_dmem_ctrl
  import dsd_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        Stall_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [29:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [1:0]  wb_ctrl_o,
  output logic [31:0] wb_alu_o,
  output logic [31:0] wb_mdata_o,
  output logic [4:0]  wb_rd_o,
  output logic        misalign_err_o,
  output logic        timeout_err_o
);

  state_t state, next_state;
  logic   memop, aligned, expired;
  logic   issue, complete, abort, misalign;

  assign memop   = is_memop(ctrl_i);
  assign aligned = (ALUResult_i[1:0] == 2'b00);

  assign wb_ctrl_o = {ctrl_i[CTRL_REGWRITE], ctrl_i[CTRL_MEMTOREG]};
  assign wb_alu_o  = ALUResult_i;
  assign wb_rd_o   = RDaddr_i;

  dmem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (issue),
    .enable  ((state == S_BUSY) && !dmem_ready_i),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE waits for the external stall to lift so the held instruction is not reissued.
  always_comb begin
    next_state = state;
    stall_o    = 1'b0;
    issue      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    misalign   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (memop) begin
          if (aligned) begin
            stall_o    = 1'b1;
            issue      = 1'b1;
            next_state = S_BUSY;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (dmem_ready_i) begin
          complete   = 1'b1;
          next_state = S_DONE;
        end else if (expired) begin
          abort      = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (!Stall_i) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_wdata_o   <= '0;
      wb_mdata_o     <= '0;
      misalign_err_o <= 1'b0;
      timeout_err_o  <= 1'b0;
    end else begin
      if (issue) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= ctrl_i[CTRL_MEMWRITE];
        dmem_addr_o  <= ALUResult_i[31:2];
        dmem_wdata_o <= RS2data_i;
      end
      if (complete || abort) begin
        dmem_req_o <= 1'b0;
      end
      if (complete && !dmem_we_o) begin
        wb_mdata_o <= dmem_rdata_i;
      end
      if (abort) begin
        wb_mdata_o    <= TIMEOUT_DATA;
        timeout_err_o <= 1'b1;
      end
      if (misalign) begin
        misalign_err_o <= 1'b1;
        if (is_load(ctrl_i)) begin
          wb_mdata_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed bench for mem_stage_dmem_ctrl with a queue of expected load results
// that is drained whenever an access completes.
module tb_mem_stage_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ctrl_i;
  logic [31:0] ALUResult_i;
  logic [31:0] RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        Stall_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [29:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;
  logic [1:0]  wb_ctrl_o;
  logic [31:0] wb_alu_o;
  logic [31:0] wb_mdata_o;
  logic [4:0]  wb_rd_o;
  logic        misalign_err_o;
  logic        timeout_err_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdata_model = 32'h0;

  mem_stage_dmem_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_i         (ctrl_i),
    .ALUResult_i    (ALUResult_i),
    .RS2data_i      (RS2data_i),
    .RDaddr_i       (RDaddr_i),
    .Stall_i        (Stall_i),
    .stall_o        (stall_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_ready_i   (dmem_ready_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .wb_ctrl_o      (wb_ctrl_o),
    .wb_alu_o       (wb_alu_o),
    .wb_mdata_o     (wb_mdata_o),
    .wb_rd_o        (wb_rd_o),
    .misalign_err_o (misalign_err_o),
    .timeout_err_o  (timeout_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [31:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      mdata_model = e;
      check32(tag, wb_mdata_o, e);
    end
  endtask

  // Entered at posedge+1; returns in the DONE cycle. ready_after=0 means the cache never answers.
  task automatic do_access(input string tag, input logic [3:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ready_after,
                           input logic [31:0] rdata, input int exp_stall);
    int  stalls = 0;
    int  busy   = 0;
    bit  done   = 1'b0;
    logic load;
    load = ctrl[1] & ~ctrl[0];
    if (ready_after == 0) exp_q.push_back(32'hDEAD_BEEF);
    else if (load) exp_q.push_back(rdata);
    ctrl_i      = ctrl;
    ALUResult_i = addr;
    RS2data_i   = wdata;
    #1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (stall_o) begin
        stalls++;
        if (dmem_req_o) begin
          busy++;
          check32({tag, "_addr"}, {2'b00, dmem_addr_o}, {2'b00, addr[31:2]});
          check32({tag, "_we"}, {31'b0, dmem_we_o}, {31'b0, ctrl[0]});
          if (ctrl[0]) check32({tag, "_wdata"}, dmem_wdata_o, wdata);
          if (busy == ready_after) begin
            dmem_ready_i = 1'b1;
            dmem_rdata_i = rdata;
          end
        end
        tick();
        dmem_ready_i = 1'b0;
        dmem_rdata_i = $urandom;
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check32({tag, "_done"}, {31'b0, done}, 32'd1);
    check32({tag, "_stalls"}, stalls, exp_stall);
    check32({tag, "_req_off"}, {31'b0, dmem_req_o}, 32'd0);
    if (ready_after == 0 || load) pop_and_check({tag, "_mdata"});
    else check32({tag, "_mdata_hold"}, wb_mdata_o, mdata_model);
  endtask

  initial begin
    rst          = 1'b1;
    ctrl_i       = 4'b0;
    ALUResult_i  = 32'h0;
    RS2data_i    = 32'h0;
    RDaddr_i     = 5'd0;
    Stall_i      = 1'b0;
    dmem_ready_i = 1'b0;
    dmem_rdata_i = 32'h0;
    #2;
    check32("rst_req", {31'b0, dmem_req_o}, 32'd0);
    check32("rst_addr", {2'b00, dmem_addr_o}, 32'd0);
    check32("rst_mdata", wb_mdata_o, 32'd0);
    check32("rst_errs", {30'b0, misalign_err_o, timeout_err_o}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Load, ready in first BUSY cycle.
    do_access("load", 4'b1110, 32'h100, 32'h0, 1, 32'h1234_5678, 2);
    ctrl_i = 4'b0;
    tick();

    // Store with three BUSY cycles.
    do_access("store", 4'b0001, 32'h200, 32'hCAFE_F00D, 3, 32'h0BAD_0BAD, 4);
    ctrl_i = 4'b0;
    tick();

    // Non-memory op flows straight through.
    ctrl_i      = 4'b1000;
    ALUResult_i = 32'h55;
    RDaddr_i    = 5'd7;
    #1;
    check32("nonmem_stall", {31'b0, stall_o}, 32'd0);
    check32("nonmem_alu", wb_alu_o, 32'h55);
    check32("nonmem_ctrl", {30'b0, wb_ctrl_o}, 32'd2);
    check32("nonmem_rd", {27'b0, wb_rd_o}, 32'd7);
    tick();
    check32("nonmem_req", {31'b0, dmem_req_o}, 32'd0);

    // Misaligned load.
    ctrl_i      = 4'b1110;
    ALUResult_i = 32'h102;
    exp_q.push_back(32'h0);
    #1;
    check32("misal_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check32("misal_req", {31'b0, dmem_req_o}, 32'd0);
    check32("misal_flag", {31'b0, misalign_err_o}, 32'd1);
    pop_and_check("misal_mdata");
    ctrl_i = 4'b0;
    tick();
    tick();
    check32("misal_sticky", {31'b0, misalign_err_o}, 32'd1);

    // Stall_i holds DONE for three cycles without reissuing.
    do_access("held", 4'b1110, 32'h104, 32'h0, 1, 32'h7777_1111, 2);
    Stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check32("held_stall", {31'b0, stall_o}, 32'd0);
      check32("held_req", {31'b0, dmem_req_o}, 32'd0);
      tick();
    end
    Stall_i = 1'b0;
    #1;
    check32("held_exit_stall", {31'b0, stall_o}, 32'd0);
    ctrl_i = 4'b0;
    tick();
    check32("held_req_after", {31'b0, dmem_req_o}, 32'd0);
    check32("held_mdata", wb_mdata_o, 32'h7777_1111);

    // Load with no ready: abort after four BUSY cycles.
    check32("pre_timeout_flag", {31'b0, timeout_err_o}, 32'd0);
    do_access("timeout", 4'b1110, 32'h108, 32'h0, 0, 32'h0, 5);
    check32("timeout_flag", {31'b0, timeout_err_o}, 32'd1);
    ctrl_i = 4'b0;
    tick();
    tick();
    check32("timeout_sticky", {31'b0, timeout_err_o}, 32'd1);

    // Asynchronous reset while BUSY.
    ctrl_i      = 4'b1110;
    ALUResult_i = 32'h300;
    #1;
    check32("rbusy_issue_stall", {31'b0, stall_o}, 32'd1);
    tick();
    check32("rbusy_req", {31'b0, dmem_req_o}, 32'd1);
    ctrl_i = 4'b0;
    rst    = 1'b1;
    #1;
    check32("rbusy_req_drop", {31'b0, dmem_req_o}, 32'd0);
    check32("rbusy_stall", {31'b0, stall_o}, 32'd0);
    check32("rbusy_errs", {30'b0, misalign_err_o, timeout_err_o}, 32'd0);
    check32("rbusy_mdata", wb_mdata_o, 32'd0);
    mdata_model = 32'h0;
    #2;
    rst = 1'b0;
    tick();
    do_access("after_rst", 4'b1110, 32'h400, 32'h0, 2, 32'hA5A5_0F0F, 3);
    ctrl_i = 4'b0;
    tick();

    check32("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
